display_scan: RTL

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_if.sv | 39 +++
 rtl/display_scan.sv | 89 ++++++++
 2 files changed

// File: rtl/display_scan_if.sv
// Bus between the display scanner and its environment: scan control and the
// nibble-mux return path in, digit select and display drive out.
interface display_scan_if;
  logic       en;
  logic [3:0] digit;
  logic [3:0] blank;
  logic [3:0] dp_in;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       tick;

  // Environment side: drives enable, the muxed nibble and per-digit controls.
  modport master (
    output en,
    output digit,
    output blank,
    output dp_in,
    input  sel,
    input  an,
    input  seg,
    input  dp,
    input  tick
  );

  // Scanner side.
  modport slave (
    input  en,
    input  digit,
    input  blank,
    input  dp_in,
    output sel,
    output an,
    output seg,
    output dp,
    output tick
  );
endinterface

// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scanner. Each digit slot lasts DIV
// clocks: DIV-1 lit cycles followed by one dead cycle (all anodes off) in
// which sel advances, so two anodes are never on together. All outputs are
// registered; an/seg/dp follow sel by one clock.
module display_scan #(
  parameter int unsigned DIV = 100000
) (
  input logic           clk,
  input logic           rst_n,
  display_scan_if.slave bus
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [1:0]      sel_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  logic            tick_q;
  logic [6:0]      seg_dec;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    seg_dec = 7'h7F;
    unique case (bus.digit)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
    endcase
  end

  // Prescaler, digit select and registered display drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= 2'd0;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else if (!bus.en) begin
      // Paused: position is held so resuming neither skips nor repeats a slot.
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else if (cnt_q == CntMax) begin
      // Dead cycle: anodes off while sel moves; seg/dp keep their last value.
      cnt_q  <= '0;
      sel_q  <= sel_q + 2'd1;
      tick_q <= 1'b1;
      an_q   <= 4'hF;
    end else begin
      cnt_q  <= cnt_q + CntW'(1);
      tick_q <= 1'b0;
      if (bus.blank[sel_q]) begin
        an_q  <= 4'hF;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(4'b0001 << sel_q);
        seg_q <= seg_dec;
        dp_q  <= ~bus.dp_in[sel_q];
      end
    end
  end

  assign bus.sel  = sel_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.tick = tick_q;

endmodule
